// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter feeding a shared synchronous FIFO.
// Tracks committed FIFO occupancy and counts cycles spent blocked on a full FIFO.
module fifo_wr_arb #(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*WIDTH-1:0]       wdata_in,
  input  logic                        fifo_full,
  input  logic                        fifo_rd_en,
  output logic [NREQ-1:0]             gnt,
  output logic                        fifo_wr_en,
  output logic [WIDTH-1:0]            fifo_wdata,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        busy,
  output logic [CNT_WIDTH-1:0]        stall_cnt
);

  localparam int IW = $clog2(NREQ);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    BLOCKED = 2'd2
  } state_t;

  state_t            state;
  logic [IW-1:0]     last_gnt;

  logic [NREQ-1:0]   eligible;
  logic [NREQ-1:0]   elig_shift;
  logic              found;
  logic [IW-1:0]     win;
  logic [WIDTH-1:0]  sel_data;
  int unsigned       idx;
  logic              room;
  logic              can_grant;
  logic              blocked;
  logic              dec;

  // A requester whose grant is visible this cycle still shows its old req at the
  // closing edge, so it is masked out to avoid a double transfer.
  always_comb begin
    eligible   = req & ~gnt;
    found      = 1'b0;
    win        = '0;
    sel_data   = '0;
    idx        = '0;
    elig_shift = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx        = (32'(last_gnt) + k) % 32'(NREQ);
      elig_shift = eligible >> idx;
      if (!found && elig_shift[0]) begin
        found    = 1'b1;
        win      = IW'(idx);
        sel_data = WIDTH'(wdata_in >> (idx * 32'(WIDTH)));
      end
    end
  end

  assign room      = !fifo_full && (level < DEPTH_L);
  assign can_grant = en && found && room;
  assign blocked   = en && found && !room;
  assign dec       = fifo_rd_en && (level != '0);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_gnt   <= IW'(NREQ - 1);
      gnt        <= '0;
      fifo_wr_en <= 1'b0;
      fifo_wdata <= '0;
      level      <= '0;
      stall_cnt  <= '0;
    end else begin
      if (can_grant) begin
        state      <= GRANT;
        last_gnt   <= win;
        gnt        <= NREQ'(1) << win;
        fifo_wr_en <= 1'b1;
        fifo_wdata <= sel_data;
      end else begin
        state      <= blocked ? BLOCKED : IDLE;
        gnt        <= '0;
        fifo_wr_en <= 1'b0;
      end

      if (blocked && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;

      case ({can_grant, dec})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter WIDTH, default 8, data width of each requester and of the FIFO write port.
REQ-002 Parameter NREQ, default 4, number of requesters (2..8).
REQ-003 Parameter DEPTH, default 16, FIFO capacity tracked by the occupancy counter.
REQ-004 Parameter CNT_WIDTH, default 8, stall counter width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  arbitration enable; 0 = no new grants.
REQ-008 req  input  NREQ  per-requester write request, bit i = requester i.
REQ-009 wdata_in  input  NREQ*WIDTH  requester data, slice [i*WIDTH +: WIDTH] belongs to requester i.
REQ-010 fifo_full  input  1  full flag from the shared sync FIFO.
REQ-011 fifo_rd_en  input  1  read strobe of the shared FIFO, observed for occupancy.
REQ-012 gnt  output  NREQ  one-hot grant pulse, registered.
REQ-013 fifo_wr_en  output  1  FIFO write enable, registered.
REQ-014 fifo_wdata  output  WIDTH  FIFO write data, registered.
REQ-015 level  output  $clog2(DEPTH)+1  committed occupancy count.
REQ-016 busy  output  1  high when state is not IDLE.
REQ-017 stall_cnt  output  CNT_WIDTH  cycles spent in BLOCKED, saturating.

Function
REQ-018 Grant decision is made at a rising edge from sampled req, en, fifo_full and level; gnt, fifo_wr_en and fifo_wdata for that decision are valid during the following cycle (latency 1).
REQ-019 Eligible set = req minus the requester whose gnt bit is currently high (its req is stale for that edge).
REQ-020 A grant is issued only when en=1, fifo_full=0, level<DEPTH and eligible set is non-empty.
REQ-021 Selection is round-robin: search starts at (last_gnt+1) mod NREQ and takes the first eligible index; last_gnt updates to the winner.
REQ-022 On a grant to i: gnt=(1<<i), fifo_wr_en=1, fifo_wdata=wdata_in slice i, all for exactly one cycle.
REQ-023 No grant at an edge: gnt=0, fifo_wr_en=0, fifo_wdata holds its previous value.
REQ-024 Requester handshake: requester holds req and its data stable until it sees its gnt bit high; the transfer completes in that gnt cycle; it may change data or drop req at the edge ending that cycle.
REQ-025 A single continuously requesting requester alone is granted every other cycle.
REQ-026 level: +1 on edge issuing a grant; -1 on edge where fifo_rd_en=1 and level>0; both -> unchanged; fifo_rd_en with level=0 ignored.
REQ-027 level never exceeds DEPTH and never wraps below 0.
REQ-028 States: IDLE (no eligible request or en=0), GRANT (grant issued at last edge), BLOCKED (eligible request, en=1, but fifo_full=1 or level=DEPTH).
REQ-029 Transitions evaluated each edge from the same conditions as REQ-020; BLOCKED->GRANT as soon as a slot frees; any state->IDLE when en=0 or no eligible request.
REQ-030 stall_cnt increments by 1 on every edge entering or remaining in BLOCKED, saturates at 2^CNT_WIDTH-1, cleared only by reset.
REQ-031 Deasserting en mid-stream: a grant already registered completes; no further grants.

Reset
REQ-032 rst=0 asynchronously forces gnt=0, fifo_wr_en=0, fifo_wdata=0, level=0, busy=0, stall_cnt=0, state=IDLE, last_gnt=NREQ-1.
REQ-033 First grant after reset goes to the lowest-index eligible requester.
REQ-034 Reset asserted mid-grant drops fifo_wr_en in the same cycle; no partial write is counted.

Verification
REQ-035 Reset, then req=4'b1111 held, en=1, no reads -> gnt sequence 0001,0010,0100,1000,0001,... on consecutive cycles, fifo_wr_en high each cycle, fifo_wdata matches granted slice.
REQ-036 Only req[2]=1 held -> gnt=0100 every other cycle, fifo_wr_en=1 every other cycle.
REQ-037 Fill: req=4'b1111, no reads -> exactly 16 grants, level=16, state BLOCKED, stall_cnt increments each further cycle; one fifo_rd_en pulse -> level 15 then exactly one more grant.
REQ-038 Simultaneous grant and fifo_rd_en at level=8 -> level stays 8.
REQ-039 fifo_full=1 with level=3 and req=4'b0001 -> no grant, busy=1, stall_cnt counts; fifo_full=0 -> gnt=0001 next cycle.
REQ-040 Assert rst low while gnt=0010 -> all outputs 0 immediately; after release, req=4'b1111 -> first gnt=0001.
